// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if
//   Groups the fetch stage's handshake signals: redirect input, the
//   instruction-memory request/response channel and the IF->ID valid/ready
//   channel.
//   master : the fetch unit (drives imem request and the IF output)
//   slave  : the environment (memory, ID stage, redirect source)
interface if_fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] pc_if;
  logic [31:0] inst_if;

  modport master (
    input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, if_valid, pc_if, inst_if
  );

  modport slave (
    output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, if_valid, pc_if, inst_if
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch stage. Issues one outstanding request at a time to
//   instruction memory, buffers the returned instruction and offers it to ID
//   over a valid/ready handshake. Redirects restart fetch at a new PC and
//   drop any response that is still in flight.
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   bus (master)   : redirect/redirect_pc, imem_req_*, imem_rsp_*,
//                    if_valid/id_ready, pc_if/inst_if
// Optional feature (macro IF_PERF_CNT_EN)
//   perf_fetch_cnt : IF->ID transfers
//   perf_stall_cnt : cycles with if_valid && !id_ready
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_unit_if.master   bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        out_valid_q, out_valid_d;
  logic        discard_q, discard_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] inst_if_q, inst_if_d;

  logic req_valid, req_fire, xfer;

  // Only issue when the output buffer is empty or draining this cycle, so a
  // response always finds room. Redirect masks the request so a stale
  // address is never accepted.
  assign req_valid = (state_q == S_REQ) && !bus.redirect && (!out_valid_q || bus.id_ready);
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign xfer      = out_valid_q && bus.id_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = out_valid_q;
  assign bus.pc_if          = pc_if_q;
  assign bus.inst_if        = inst_if_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    out_valid_d = out_valid_q;
    discard_d   = discard_q;
    pc_if_d     = pc_if_q;
    inst_if_d   = inst_if_q;

    if (xfer) out_valid_d = 1'b0;

    if (bus.redirect) begin
      fetch_pc_d  = bus.redirect_pc;
      out_valid_d = 1'b0;
      if (state_q == S_WAIT && !bus.imem_rsp_valid) begin
        // Response still in flight: remember to drop it. A repeated redirect
        // lands here too and keeps discard set.
        discard_d = 1'b1;
      end else begin
        // Response (if any) arriving now is simply not loaded.
        discard_d = 1'b0;
        state_d   = S_REQ;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  if (req_fire) state_d = S_WAIT;
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              inst_if_d   = bus.imem_rsp_data;
              pc_if_d     = fetch_pc_q;
              out_valid_d = 1'b1;
              fetch_pc_d  = fetch_pc_q + PC_STEP;
            end
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, xfer};
    perf_stall_d = perf_stall_q + {31'd0, out_valid_q && !bus.id_ready};
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      out_valid_q <= 1'b0;
      discard_q   <= 1'b0;
      pc_if_q     <= RESET_PC;
      inst_if_q   <= 32'd0;
`ifdef IF_PERF_CNT_EN
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      out_valid_q <= out_valid_d;
      discard_q   <= discard_d;
      pc_if_q     <= pc_if_d;
      inst_if_q   <= inst_if_d;
`ifdef IF_PERF_CNT_EN
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk, rst;
  if_fetch_unit_if bus();
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  if_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;

  // memory model: one pending response with a countdown
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          lat_next;

  // reference model: next PC ID must see, next address memory must be asked for
  logic [31:0] exp_pc, exp_req;
  int          m_xfer, m_stall;

  bit          p_rdr, p_stall, p_wait;
  logic [31:0] p_pc, p_inst, p_addr;

  bit          o_req, o_hs, o_xfer, o_ifv, o_rsp;
  logic [31:0] o_addr, o_pc, o_inst;
  int          cyc_n, last_xfer_cyc;
  logic [31:0] hs_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1 + 32'h1234_5678) ^ (a >> 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    pend = 0; pend_cnt = 0; pend_addr = 0;
    exp_pc = RST_PC; exp_req = RST_PC;
    m_xfer = 0; m_stall = 0;
    p_rdr = 0; p_stall = 0; p_wait = 0; p_pc = 0; p_inst = 0; p_addr = 0;
    bus.imem_rsp_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_if_valid"},  {31'd0, bus.if_valid}, 32'd0);
    chk({pfx, "_req_valid"}, {31'd0, bus.imem_req_valid}, 32'd0);
    chk({pfx, "_pc_if"},     bus.pc_if, RST_PC);
    chk({pfx, "_inst_if"},   bus.inst_if, 32'd0);
    chk({pfx, "_req_addr"},  bus.imem_req_addr, RST_PC);
`ifdef IF_PERF_CNT_EN
    chk({pfx, "_perf_fetch"}, perf_fetch_cnt, 32'd0);
    chk({pfx, "_perf_stall"}, perf_stall_cnt, 32'd0);
`endif
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic cyc(input bit rdr, input logic [31:0] rpc, input bit idr, input bit mrdy);
    bit rsp;
    cyc_n++;
    bus.redirect       = rdr;
    bus.redirect_pc    = rpc;
    bus.id_ready       = idr;
    bus.imem_req_ready = mrdy;
    rsp = pend && (pend_cnt == 0);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? memf(pend_addr) : $urandom;
    #1;
    o_rsp  = rsp;
    o_req  = bus.imem_req_valid;
    o_addr = bus.imem_req_addr;
    o_ifv  = bus.if_valid;
    o_pc   = bus.pc_if;
    o_inst = bus.inst_if;
    o_hs   = o_req && mrdy;
    o_xfer = o_ifv && idr;

    if (rdr)     chk("req_masked_by_redirect", {31'd0, o_req}, 32'd0);
    if (p_rdr)   chk("flushed_after_redirect", {31'd0, o_ifv}, 32'd0);
    if (p_stall) begin
      chk("hold_valid", {31'd0, o_ifv}, 32'd1);
      chk("hold_pc", o_pc, p_pc);
      chk("hold_inst", o_inst, p_inst);
    end
    if (p_wait && o_req) chk("req_addr_stable", o_addr, p_addr);
    if (o_hs) begin
      chk("req_addr", o_addr, exp_req);
      hs_q.push_back(o_addr);
      exp_req = o_addr + 32'd4;
    end
    if (o_xfer) begin
      chk("xfer_pc", o_pc, exp_pc);
      chk("xfer_inst", o_inst, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      m_xfer++;
    end
    if (o_ifv && !idr) m_stall++;

    if (rsp) pend = 0;
    else if (pend) pend_cnt--;
    if (o_hs) begin
      pend = 1; pend_cnt = lat_next - 1; pend_addr = o_addr;
    end
    if (rdr) begin
      exp_pc = rpc; exp_req = rpc;
    end
    p_rdr   = rdr;
    p_stall = o_ifv && !idr && !rdr;
    p_pc    = o_pc;
    p_inst  = o_inst;
    p_wait  = o_req && !mrdy && !rdr;
    p_addr  = o_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc_n = 0;
    rst = 1'b1;
    bus.redirect = 0; bus.redirect_pc = 0; bus.id_ready = 0;
    bus.imem_req_ready = 0; bus.imem_rsp_data = 0;
    lat_next = 1;
    model_reset();
    @(negedge clk);
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    // IDLE lasts one cycle
    cyc(0, 0, 1, 1);
    chk("idle_no_req", {31'd0, o_req}, 32'd0);

    // streaming with single-cycle memory
    hs_q.delete();
    last_xfer_cyc = -1;
    for (int b = 0; b < 20 && m_xfer < 3; b++) begin
      cyc(0, 0, 1, 1);
      if (o_xfer) begin
        if (last_xfer_cyc >= 0) chk("xfer_spacing", cyc_n - last_xfer_cyc, 32'd2);
        last_xfer_cyc = cyc_n;
      end
    end
    chk("three_xfers", m_xfer, 32'd3);
    chk("req0", hs_q[0], 32'h8000_0000);
    chk("req1", hs_q[1], 32'h8000_0004);
    chk("req2", hs_q[2], 32'h8000_0008);

    // ID back-pressure for 5 cycles
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1);
      chk("stall_if_valid", {31'd0, o_ifv}, 32'd1);
      chk("stall_no_req", {31'd0, o_req}, 32'd0);
    end
    cyc(0, 0, 1, 1);
    chk("release_req", {31'd0, o_req}, 32'd1);
    chk("release_xfer", {31'd0, o_xfer}, 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("perf_stall_5", perf_stall_cnt, 32'd5);
    chk("perf_fetch", perf_fetch_cnt, m_xfer);
`endif

    // redirect while waiting, response arrives 3 cycles later
    lat_next = 4;
    o_hs = 0;
    for (int b = 0; b < 8 && !o_hs; b++) cyc(0, 0, 1, 1);
    chk("hs_before_redirect", {31'd0, o_hs}, 32'd1);
    cyc(1, 32'h8000_1000, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1);
      chk("discard_if_valid", {31'd0, o_ifv}, 32'd0);
      chk("discard_no_req", {31'd0, o_req}, 32'd0);
    end
    lat_next = 2;
    cyc(0, 0, 1, 1);
    chk("redir_req_hs", {31'd0, o_hs}, 32'd1);
    chk("redir_req_addr", o_addr, 32'h8000_1000);
    chk("redir_if_valid", {31'd0, o_ifv}, 32'd0);

    // redirect in the same cycle as the response
    cyc(0, 0, 1, 1);
    lat_next = 1;
    cyc(1, 32'h8000_2000, 1, 1);
    chk("rsp_with_redirect", {31'd0, o_rsp}, 32'd1);
    cyc(0, 0, 1, 1);
    chk("redir2_hs", {31'd0, o_hs}, 32'd1);
    chk("redir2_addr", o_addr, 32'h8000_2000);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    chk("redir2_xfer", {31'd0, o_xfer}, 32'd1);
    chk("redir2_pc", o_pc, 32'h8000_2000);
    cyc(0, 0, 1, 1);

    // memory not ready for 4 cycles
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      chk("mem_stall_req", {31'd0, o_req}, 32'd1);
      chk("mem_stall_addr", o_addr, 32'h8000_2008);
    end
    lat_next = 3;
    cyc(0, 0, 1, 1);
    chk("mem_release_hs", {31'd0, o_hs}, 32'd1);

    // asynchronous reset in the middle of WAIT
    #3 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 1, 1);
    chk("post_rst_idle", {31'd0, o_req}, 32'd0);
    cyc(0, 0, 1, 1);
    chk("post_rst_hs", {31'd0, o_hs}, 32'd1);
    chk("post_rst_addr", o_addr, RST_PC);

    // randomized traffic, including redirects near the top of the address space
    for (int i = 0; i < 600; i++) begin
      bit rdr, idr, mrdy;
      logic [31:0] rpc;
      rdr  = ($urandom_range(15) == 0);
      rpc  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      idr  = ($urandom_range(3) != 0);
      mrdy = ($urandom_range(2) != 0);
      lat_next = $urandom_range(4, 1);
      cyc(rdr, rpc, idr, mrdy);
    end
    chk("random_progress", {31'd0, m_xfer > 50}, 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_final", perf_fetch_cnt, m_xfer);
    chk("perf_stall_final", perf_stall_cnt, m_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Producer side of the IF->ID valid/ready handshake.
- Generates fetch addresses, issues single-outstanding requests to instruction memory, and buffers the returned instruction.
- Presents pc_if/inst_if with if_valid to the ID segment register, which answers with id_ready.
- Accepts redirects (branch/jump/exception) from later stages and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- redirect  input  1  flush IF and restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address
- imem_rsp_valid  input  1  response valid; no back-pressure; arrives >=1 cycle after request handshake
- imem_rsp_data  input  32  fetched instruction
- if_valid  output  1  pc_if/inst_if valid toward ID
- id_ready  input  1  ID accepts this cycle
- pc_if  output  32  PC of buffered instruction
- inst_if  output  32  buffered instruction

Behaviour:
- Reset, asynchronous, active-high; every listed value holds while rst=1:
  - fetch_pc=RESET_PC, state=IDLE, out_valid=0, discard=0.
  - if_valid=0, imem_req_valid=0, pc_if=RESET_PC, inst_if=0.
  - imem_req_addr=fetch_pc=RESET_PC.
- States: IDLE, REQ, WAIT.
  - IDLE: one cycle after reset release -> REQ.
  - REQ: imem_req_valid = !redirect && (!out_valid || id_ready). imem_req_addr = fetch_pc. On handshake (valid && ready) -> WAIT.
  - WAIT: on imem_rsp_valid:
    - discard=0: inst_if<=rsp_data, pc_if<=fetch_pc, out_valid<=1, fetch_pc<=fetch_pc+PC_STEP (32-bit wrap, 0xFFFF_FFFC+4=0), -> REQ.
    - discard=1: drop the data, discard<=0, -> REQ.
- Issue gating guarantees buffer space. The output buffer is empty or being drained at request issue, so a response never finds out_valid=1.
- if_valid = out_valid. Transfer happens when if_valid && id_ready; out_valid clears unless a new response loads in the same cycle.
- pc_if/inst_if stay stable while if_valid && !id_ready.
- Throughput: max one instruction per 2 cycles with single-cycle memory. One outstanding request maximum.
- Redirect has priority over everything except rst:
  - fetch_pc<=redirect_pc, out_valid<=0.
  - imem_req_valid forced 0 in the redirect cycle, so no request with a stale address is accepted.
  - In WAIT with no rsp_valid in the same cycle: discard<=1, stay WAIT.
  - In WAIT with rsp_valid in the same cycle: response dropped, discard<=0, -> REQ.
  - In REQ or IDLE: -> REQ.
  - A second redirect while discard=1 only updates fetch_pc; discard stays 1.
- imem_req_addr changes while imem_req_valid=1 only across a redirect. Valid deasserts that cycle, so the request is stable while valid.
- Reset mid-transaction returns to the reset state immediately. A response arriving after reset release, while in IDLE/REQ, is ignored; the environment must not deliver late responses.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt increments on each IF->ID transfer.
  - perf_stall_cnt increments each cycle with if_valid && !id_ready.
- Not defined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Reset, memory ready and 1-cycle response, id_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008; ID receives three instructions, one every 2 cycles, pc_if matching.
- id_ready=0 for 5 cycles with if_valid=1 -> pc_if/inst_if frozen, no new imem_req_valid; release -> next request issued that cycle.
- Redirect to 0x80001000 while in WAIT, response arriving 3 cycles later -> response dropped, if_valid stays 0, next request addr=0x80001000.
- Redirect in the same cycle as rsp_valid -> response dropped, next request to redirect_pc, no discard of the following response.
- imem_req_ready=0 for 4 cycles -> imem_req_valid held and addr stable; rst asserted mid-WAIT -> outputs return to reset values asynchronously; first request after release at 0x80000000.
- With IF_PERF_CNT_EN: 3 transfers plus 5 stall cycles -> perf_fetch_cnt=3, perf_stall_cnt=5.
